// File: rtl/fifo_read_stream.sv
// Read-side drain stage: pops a dual-clock FIFO read port into a 2-entry
// buffer and presents the words as a registered valid/ready stream.
module fifo_read_stream #(
  parameter int unsigned DATASIZE  = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 rclk,
  input  logic                 rreset,
  input  logic                 rempty,
  input  logic [DATASIZE-1:0]  rdata,
  output logic                 rinc,
  input  logic                 flush,
  output logic                 m_valid,
  output logic [DATASIZE-1:0]  m_data,
  input  logic                 m_ready,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] word_count
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t                occ, occ_next;
  logic [DATASIZE-1:0] head, tail, head_d;
  logic                push, deliver, head_load, tail_load;

  // Pop decision uses only local state so m_ready never reaches rinc.
  assign rinc      = !rreset && !flush && !rempty && (occ != OCC_FULL);
  assign push      = rinc;
  assign m_valid   = (occ != OCC_EMPTY);
  assign deliver   = m_valid && m_ready;
  assign m_data    = head;
  assign occupancy = occ;
  assign head_d    = (occ == OCC_FULL) ? tail : rdata;

  always_comb begin
    occ_next  = occ;
    head_load = 1'b0;
    tail_load = 1'b0;
    if (flush) begin
      occ_next = OCC_EMPTY;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (push) begin
            head_load = 1'b1;
            occ_next  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && deliver) begin
            head_load = 1'b1;
          end else if (push) begin
            tail_load = 1'b1;
            occ_next  = OCC_FULL;
          end else if (deliver) begin
            occ_next = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (deliver) begin
            head_load = 1'b1;
            occ_next  = OCC_ONE;
          end
        end
        default: occ_next = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge rclk or posedge rreset) begin
    if (rreset) begin
      occ        <= OCC_EMPTY;
      head       <= '0;
      tail       <= '0;
      word_count <= '0;
    end else begin
      occ <= occ_next;
      if (head_load) head <= head_d;
      if (tail_load) tail <= rdata;
      // Deliveries in a flush cycle still count.
      if (deliver) word_count <= word_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream: queue-based model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_fifo_read_stream;

  logic       rclk = 1'b0;
  logic       rreset, rempty, flush, m_ready;
  logic [7:0] rdata;
  logic       rinc, m_valid;
  logic [7:0] m_data;
  logic [1:0] occupancy;
  logic [15:0] word_count;
  logic       rinc4, m_valid4;
  logic [7:0] m_data4;
  logic [1:0] occ4;
  logic [3:0] count4;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] mbuf[$];
  logic [7:0] mhead = 8'h00;
  int unsigned mcount = 0;

  always #5 rclk = ~rclk;

  fifo_read_stream #(.DATASIZE(8), .CNT_WIDTH(16)) dut (
    .rclk(rclk), .rreset(rreset), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .flush(flush), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .occupancy(occupancy), .word_count(word_count)
  );

  fifo_read_stream #(.DATASIZE(8), .CNT_WIDTH(4)) dut4 (
    .rclk(rclk), .rreset(rreset), .rempty(rempty), .rdata(rdata), .rinc(rinc4),
    .flush(flush), .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready),
    .occupancy(occ4), .word_count(count4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare current outputs, then advance the model to the state after the next edge.
  always @(negedge rclk) begin
    logic exp_rinc;
    logic dlv;
    if (rreset) begin
      mbuf.delete();
      mhead  = 8'h00;
      mcount = 0;
    end
    exp_rinc = !rreset && !flush && !rempty && (mbuf.size() < 2);
    check("rinc", rinc, exp_rinc);
    check("m_valid", m_valid, mbuf.size() != 0);
    check("m_data", m_data, mhead);
    check("occupancy", occupancy, mbuf.size());
    check("word_count", word_count, mcount % 65536);
    check("rinc_w4", rinc4, exp_rinc);
    check("m_valid_w4", m_valid4, mbuf.size() != 0);
    check("m_data_w4", m_data4, mhead);
    check("occupancy_w4", occ4, mbuf.size());
    check("word_count_w4", count4, mcount % 16);
    if (!rreset) begin
      dlv = (mbuf.size() != 0) && m_ready;
      if (dlv) begin
        mcount++;
        void'(mbuf.pop_front());
      end
      if (flush) mbuf.delete();
      else if (exp_rinc) begin
        mbuf.push_back(rdata);
        void'(fifo_q.pop_front());
      end
      if (mbuf.size() != 0) mhead = mbuf[0];
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
    rempty = (fifo_q.size() == 0);
    if (fifo_q.size() != 0) rdata = fifo_q[0];
    #1;
  endtask

  task automatic do_reset();
    rreset  = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;
    fifo_q.delete();
    tick();
    tick();
    rreset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rreset = 1'b1; rempty = 1'b1; rdata = 8'h00; flush = 1'b0; m_ready = 1'b0;
    tick();
    tick();
    check("reset_m_valid", m_valid, 0);
    check("reset_m_data", m_data, 0);
    check("reset_occupancy", occupancy, 0);
    check("reset_word_count", word_count, 0);
    check("reset_rinc", rinc, 0);
    rreset = 1'b0;
    #1;

    // Single word
    fifo_q.push_back(8'hA5);
    m_ready = 1'b1;
    tick();
    check("single_rinc", rinc, 1);
    tick();
    check("single_valid", m_valid, 1);
    check("single_data", m_data, 8'hA5);
    check("single_rinc_off", rinc, 0);
    tick();
    check("single_done_valid", m_valid, 0);
    check("single_count", word_count, 1);
    check("single_occ", occupancy, 0);
    check("single_data_hold", m_data, 8'hA5);

    // Streaming 0x01..0x10
    do_reset();
    for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
    m_ready = 1'b1;
    tick();
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("stream_valid", m_valid, 1);
      check("stream_data", m_data, i);
      check("stream_occ", occupancy, 1);
    end
    tick();
    check("stream_end_valid", m_valid, 0);
    check("stream_count", word_count, 16);

    // Back-pressure
    do_reset();
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'h40 + 8'(i));
    tick();
    check("bp_rinc0", rinc, 1);
    tick();
    check("bp_occ1", occupancy, 1);
    check("bp_rinc1", rinc, 1);
    tick();
    check("bp_occ2", occupancy, 2);
    check("bp_rinc2", rinc, 0);
    check("bp_data", m_data, 8'h40);
    tick();
    tick();
    check("bp_hold_occ", occupancy, 2);
    check("bp_hold_data", m_data, 8'h40);
    m_ready = 1'b1;
    #1;
    check("bp_no_ready_path", rinc, 0);
    tick();
    check("bp_rel_data", m_data, 8'h41);
    check("bp_rel_rinc", rinc, 1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("bp_rel_valid", m_valid, 1);
      check("bp_rel_seq", m_data, 8'h40 + 8'(i));
    end
    tick();
    check("bp_count", word_count, 5);
    check("bp_end_valid", m_valid, 0);

    // Flush
    do_reset();
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    tick();
    tick();
    tick();
    check("fl_occ2", occupancy, 2);
    fifo_q.push_back(8'h33);
    tick();
    flush = 1'b1;
    #1;
    check("fl_rinc", rinc, 0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_valid", m_valid, 0);
    check("fl_occ", occupancy, 0);
    check("fl_data_hold", m_data, 8'h11);
    check("fl_rinc_after", rinc, 1);
    tick();
    check("fl_next_data", m_data, 8'h33);
    check("fl_count_kept", word_count, 0);
    m_ready = 1'b1;
    tick();
    check("fl_count", word_count, 1);

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'h80 + 8'(i));
    m_ready = 1'b1;
    for (int n = 0; n < 60 && mcount < 15; n++) tick();
    check("wrap_15", count4, 4'hF);
    check("wrap_15_w16", word_count, 15);
    tick();
    check("wrap_16", count4, 4'h0);
    tick();
    check("wrap_17", count4, 4'h1);
    check("wrap_17_w16", word_count, 17);

    // Reset mid-stream
    do_reset();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'hC0 + 8'(i));
    m_ready = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("mid_pre_count", word_count, 2);
    rreset = 1'b1;
    #1;
    check("mid_valid", m_valid, 0);
    check("mid_data", m_data, 0);
    check("mid_occ", occupancy, 0);
    check("mid_count", word_count, 0);
    check("mid_rinc", rinc, 0);
    tick();
    check("mid_rinc_hold", rinc, 0);
    rreset = 1'b0;
    #1;
    check("mid_rinc_resume", rinc, 1);
    tick();
    check("mid_resume_data", m_data, 8'hC3);
    check("mid_resume_valid", m_valid, 1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
